vga_camera_capture: RTL and testbench

VGA_CAMERA_CAPTURE -- requirements
Module: vga_camera_capture

---
 rtl/vga_camera_capture_if.sv | 30 +++
 rtl/vga_camera_capture.sv | 193 +++++++++++++++++++
 tb/tb_vga_camera_capture.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_camera_capture_if.sv
// Camera byte bus, capture controls and pixel-write outputs of the capture block.
interface vga_camera_capture_if #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int ADDR_W        = 19
);
    logic                              pclk;
    logic                              v_sync;
    logic                              h_ref;
    logic [DATA_W-1:0]                 data_in;
    logic                              capture_en;
    logic [1:0]                        decim;
    logic                              xclk;
    logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data;
    logic                              pix_valid;
    logic [ADDR_W-1:0]                 pix_addr;
    logic                              frame_done;
    logic                              line_err;
    logic [7:0]                        frame_cnt;

    modport master (
        output pclk, v_sync, h_ref, data_in, capture_en, decim,
        input  xclk, pix_data, pix_valid, pix_addr, frame_done, line_err, frame_cnt
    );

    modport slave (
        input  pclk, v_sync, h_ref, data_in, capture_en, decim,
        output xclk, pix_data, pix_valid, pix_addr, frame_done, line_err, frame_cnt
    );
endinterface

// File: rtl/vga_camera_capture.sv
// Oversamples a camera byte stream in the clk_25 domain, assembles pixels,
// decimates them and emits linear frame-buffer writes with frame/line status.
module vga_camera_capture #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int ADDR_W        = 19
) (
    input  logic                i_clk_25,
    input  logic                i_reset,
    vga_camera_capture_if.slave cam
);
    localparam int PIX_W = DATA_W * BYTES_PER_PIX;
    localparam int X_W   = ($clog2(H_ACTIVE + 1) < 3) ? 3 : $clog2(H_ACTIVE + 1);
    localparam int Y_W   = ($clog2(V_ACTIVE + 1) < 3) ? 3 : $clog2(V_ACTIVE + 1);
    localparam int BC_W  = $clog2(H_ACTIVE * BYTES_PER_PIX + 2);

    localparam logic [X_W-1:0]  X_END   = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_ACTIVE - 1);
    localparam logic [BC_W-1:0] BC_LINE = BC_W'(H_ACTIVE * BYTES_PER_PIX);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(H_ACTIVE * BYTES_PER_PIX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic              r_xclk;
    logic              r_pclk_s1, r_pclk_s2, r_pclk_prev;
    logic              r_vs_s1, r_vs_s2, r_vs_last;
    logic              r_href_s1, r_href_s2, r_href_last;
    logic [DATA_W-1:0] r_data_s1, r_data_s2;
    logic [DATA_W-1:0] r_msb;
    logic              r_phase;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [1:0]        r_decim;
    logic              r_pix_valid;
    logic [PIX_W-1:0]  r_pix_data;
    logic [ADDR_W-1:0] r_pix_addr;
    logic              r_frame_done;
    logic              r_line_err;
    logic [7:0]        r_frame_cnt;

    logic              w_pclk_rise;
    logic              w_last_byte;
    logic              w_keep;
    logic [2:0]        w_mask;
    logic [PIX_W-1:0]  w_pix_word;

    generate
        if (BYTES_PER_PIX == 1) begin : g_grey
            assign w_pix_word = r_data_s2;
        end else begin : g_rgb
            assign w_pix_word = {r_msb, r_data_s2};
        end
    endgenerate

    always_comb begin
        w_mask = 3'd0;
        case (r_decim)
            2'd0:    w_mask = 3'd0;
            2'd1:    w_mask = 3'd1;
            2'd2:    w_mask = 3'd3;
            default: w_mask = 3'd7;
        endcase
    end

    assign w_pclk_rise = r_pclk_s2 & ~r_pclk_prev;
    assign w_last_byte = (BYTES_PER_PIX == 1) || r_phase;
    assign w_keep      = ((r_x[2:0] & w_mask) == 3'd0) && ((r_y[2:0] & w_mask) == 3'd0);

    always_ff @(posedge i_clk_25) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_xclk       <= 1'b0;
            r_pclk_s1    <= 1'b0;
            r_pclk_s2    <= 1'b0;
            r_pclk_prev  <= 1'b0;
            r_vs_s1      <= 1'b0;
            r_vs_s2      <= 1'b0;
            r_vs_last    <= 1'b0;
            r_href_s1    <= 1'b0;
            r_href_s2    <= 1'b0;
            r_href_last  <= 1'b0;
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_msb        <= '0;
            r_phase      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_byte_cnt   <= '0;
            r_decim      <= 2'd0;
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_pix_addr   <= '0;
            r_frame_done <= 1'b0;
            r_line_err   <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_xclk       <= ~r_xclk;
            r_pclk_s1    <= cam.pclk;
            r_pclk_s2    <= r_pclk_s1;
            r_pclk_prev  <= r_pclk_s2;
            r_vs_s1      <= cam.v_sync;
            r_vs_s2      <= r_vs_s1;
            r_href_s1    <= cam.h_ref;
            r_href_s2    <= r_href_s1;
            r_data_s1    <= cam.data_in;
            r_data_s2    <= r_data_s1;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_pix_valid)
                r_pix_addr <= r_pix_addr + 1'b1;
            // v_sync/h_ref edges are judged only at pixel-clock sample points
            if (w_pclk_rise) begin
                r_vs_last   <= r_vs_s2;
                r_href_last <= r_href_s2;
            end
            case (r_state)
                S_IDLE: begin
                    if (cam.capture_en)
                        r_state <= S_ARM;
                end
                S_ARM: begin
                    if (w_pclk_rise && r_vs_last && !r_vs_s2) begin
                        r_state    <= S_ACTIVE;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_phase    <= 1'b0;
                        r_byte_cnt <= '0;
                        r_pix_addr <= '0;
                        r_line_err <= 1'b0;
                        r_decim    <= cam.decim;
                    end
                end
                S_ACTIVE: begin
                    if (w_pclk_rise) begin
                        if (r_vs_s2 && !r_vs_last) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 1'b1;
                            r_line_err   <= 1'b1;
                        end else if (r_href_s2) begin
                            if (r_byte_cnt != BC_MAX)
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (r_x != X_END) begin
                                if (w_last_byte) begin
                                    r_phase <= 1'b0;
                                    r_x     <= r_x + 1'b1;
                                    if (w_keep) begin
                                        r_pix_valid <= 1'b1;
                                        r_pix_data  <= w_pix_word;
                                    end
                                end else begin
                                    r_msb   <= r_data_s2;
                                    r_phase <= 1'b1;
                                end
                            end
                        end else if (r_href_last) begin
                            // line end: a pending half pixel is dropped with the phase reset
                            r_x        <= '0;
                            r_y        <= r_y + 1'b1;
                            r_phase    <= 1'b0;
                            r_byte_cnt <= '0;
                            if (r_byte_cnt != BC_LINE)
                                r_line_err <= 1'b1;
                            if (r_y == Y_LAST) begin
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= cam.capture_en ? S_ARM : S_IDLE;
                end
            endcase
        end
    end

    assign cam.xclk       = r_xclk;
    assign cam.pix_data   = r_pix_data;
    assign cam.pix_valid  = r_pix_valid;
    assign cam.pix_addr   = r_pix_addr;
    assign cam.frame_done = r_frame_done;
    assign cam.line_err   = r_line_err;
    assign cam.frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_vga_camera_capture.sv
// Directed bench for vga_camera_capture with a 4x3 RGB565 frame and pclk = clk_25/4.
module tb_vga_camera_capture;
    logic clk_25 = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_25 = ~clk_25;

    vga_camera_capture_if #(.DATA_W(8), .BYTES_PER_PIX(2), .ADDR_W(19)) cam ();

    vga_camera_capture #(
        .DATA_W(8), .BYTES_PER_PIX(2), .H_ACTIVE(4), .V_ACTIVE(3), .ADDR_W(19)
    ) dut (
        .i_clk_25(clk_25),
        .i_reset (reset),
        .cam     (cam)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_done  = 0;
    logic err_at_done = 1'b0;
    logic [15:0] v_data[$];
    logic [18:0] v_addr[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk_25) begin
        if (cam.pix_valid === 1'b1) begin
            v_data.push_back(cam.pix_data);
            v_addr.push_back(cam.pix_addr);
            n_valid++;
        end
        if (cam.frame_done === 1'b1) begin
            n_done++;
            err_at_done = cam.line_err;
        end
    end

    task automatic clear_mon();
        n_valid = 0;
        n_done  = 0;
        v_data.delete();
        v_addr.delete();
    endtask

    task automatic tick(input logic hr, input logic vs, input logic [7:0] d);
        cam.h_ref   = hr;
        cam.v_sync  = vs;
        cam.data_in = d;
        cam.pclk    = 1'b0;
        repeat (2) @(negedge clk_25);
        cam.pclk    = 1'b1;
        repeat (2) @(negedge clk_25);
    endtask

    task automatic vsync_pulse();
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
    endtask

    // short_line < 0 means every line has 8 bytes; new_decim < 0 leaves decim alone
    task automatic send_frame(input int nlines, input int short_line, input int short_len,
                              input int new_decim);
        logic [7:0] v;
        int len;
        v = 8'h01;
        vsync_pulse();
        for (int y = 0; y < nlines; y++) begin
            len = (y == short_line) ? short_len : 8;
            for (int b = 0; b < len; b++) begin
                tick(1'b1, 1'b0, v);
                v = v + 8'h01;
            end
            repeat (3) tick(1'b0, 1'b0, 8'h00);
            if (y == 0 && new_decim >= 0) cam.decim = 2'(new_decim);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {cam.xclk, cam.pix_valid, cam.frame_done, cam.line_err,
                  cam.frame_cnt, cam.pix_addr[15:0]}, 32'h0);
        chk({tag, "_data"}, {16'h0, cam.pix_data}, 32'h0);
    endtask

    initial begin
        logic [15:0] exp_dec [4];
        logic [15:0] exp_odd [11];
        exp_dec = '{16'h0102, 16'h0506, 16'h1112, 16'h1516};
        exp_odd = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090a, 16'h0b0c,
                    16'h0d0e, 16'h1011, 16'h1213, 16'h1415, 16'h1617};
        cam.pclk = 1'b0; cam.v_sync = 1'b0; cam.h_ref = 1'b0; cam.data_in = 8'h00;
        cam.capture_en = 1'b0; cam.decim = 2'd0;

        // reset state
        repeat (4) @(negedge clk_25);
        chk_outs_zero("rst");
        reset = 1'b0;
        @(negedge clk_25);
        chk("xclk_hi", {31'h0, cam.xclk}, 32'h1);
        @(negedge clk_25);
        chk("xclk_lo", {31'h0, cam.xclk}, 32'h0);
        cam.capture_en = 1'b1;
        repeat (2) @(negedge clk_25);

        // full frame, no decimation
        clear_mon();
        send_frame(3, -1, 0, -1);
        chk("f1_nvalid", n_valid, 12);
        for (int i = 0; i < 12; i++) begin
            if (i < v_addr.size()) begin
                chk("f1_addr", v_addr[i], i);
                chk("f1_data", v_data[i], {16'h0, 8'(2*i+1), 8'(2*i+2)});
            end
        end
        chk("f1_ndone", n_done, 1);
        chk("f1_cnt", cam.frame_cnt, 1);
        chk("f1_err", {31'h0, err_at_done}, 0);

        // 1:2 decimation; decim changed mid-frame must not matter
        clear_mon();
        cam.decim = 2'd1;
        send_frame(3, -1, 0, 0);
        chk("f2_nvalid", n_valid, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < v_addr.size()) begin
                chk("f2_addr", v_addr[i], i);
                chk("f2_data", v_data[i], {16'h0, exp_dec[i]});
            end
        end
        chk("f2_cnt", cam.frame_cnt, 2);

        // line 1 has 7 bytes
        clear_mon();
        cam.decim = 2'd0;
        send_frame(3, 1, 7, -1);
        chk("f3_nvalid", n_valid, 11);
        for (int i = 0; i < 11; i++) begin
            if (i < v_data.size()) chk("f3_data", v_data[i], {16'h0, exp_odd[i]});
        end
        chk("f3_err_done", {31'h0, err_at_done}, 1);
        chk("f3_err_sticky", {31'h0, cam.line_err}, 1);
        chk("f3_cnt", cam.frame_cnt, 3);

        // v_sync rises after 2 lines
        clear_mon();
        send_frame(2, -1, 0, -1);
        chk("f4_err_cleared", {31'h0, cam.line_err}, 0);
        chk("f4_nvalid", n_valid, 8);
        chk("f4_ndone_pre", n_done, 0);
        cam.capture_en = 1'b0;
        vsync_pulse();
        chk("f4_ndone", n_done, 1);
        chk("f4_err_done", {31'h0, err_at_done}, 1);
        chk("f4_cnt", cam.frame_cnt, 4);
        cam.capture_en = 1'b1;
        repeat (2) @(negedge clk_25);

        // reset at pixel 5
        clear_mon();
        fork
            send_frame(3, -1, 0, -1);
            begin
                for (int i = 0; i < 5000 && n_valid < 5; i++) @(negedge clk_25);
                chk("f5_reach5", {31'h0, n_valid >= 5}, 1);
                reset = 1'b1;
                @(negedge clk_25);
                chk_outs_zero("f5_rst");
                reset = 1'b0;
            end
        join
        chk("f5_nvalid", n_valid, 5);
        chk("f5_ndone", n_done, 0);
        clear_mon();
        send_frame(3, -1, 0, -1);
        chk("f6_nvalid", n_valid, 12);
        if (v_addr.size() > 0) chk("f6_addr0", v_addr[0], 0);
        if (v_addr.size() == 12) chk("f6_addr11", v_addr[11], 11);
        chk("f6_ndone", n_done, 1);
        chk("f6_cnt", cam.frame_cnt, 1);

        // frame counter wrap: first pulse starts a frame, each later one truncates it
        clear_mon();
        repeat (255) vsync_pulse();
        chk("wrap_255", cam.frame_cnt, 255);
        vsync_pulse();
        chk("wrap_0", cam.frame_cnt, 0);
        chk("wrap_ndone", n_done, 255);
        chk("wrap_nvalid", n_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
